// File: rtl/accumulator_serial.sv
// WIDTH-bit accumulator/constant pair, loaded by nybble. ALU ops process one nybble per cycle.
// Define ACCUMULATOR_SERIAL_PARALLEL_EN to run ALU ops full-width in a single EXEC cycle.
module accumulator_serial #(
  parameter  int WIDTH = 16,
  localparam int NYB   = WIDTH / 4,
  localparam int SELW  = (NYB > 1) ? $clog2(NYB) : 1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [4:0]       rx_opcode,
  input  logic [SELW-1:0]  rx_sel,
  input  logic [3:0]       rx_operand,
  input  logic             rx_carry,
  output logic [WIDTH-1:0] tx_accumulator,
  output logic             tx_zero,
  output logic             tx_sign,
  output logic             tx_carry,
  output logic             tx_overflow,
  output logic             tx_busy,
  output logic             tx_done
);
`ifdef ACCUMULATOR_SERIAL_PARALLEL_EN
  localparam int LW = WIDTH;
`else
  localparam int LW = 4;
`endif

  localparam logic [4:0] OP_LDA  = 5'd1;
  localparam logic [4:0] OP_LDK  = 5'd2;
  localparam logic [4:0] OP_CLR  = 5'd3;
  localparam logic [4:0] OP_ADC  = 5'd4;
  localparam logic [4:0] OP_SBC  = 5'd6;
  localparam logic [4:0] OP_SUB  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_XCHG = 5'd11;

  typedef enum logic {S_IDLE, S_EXEC} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] acc, konst;
  logic [4:0]       op_q;
  logic [SELW-1:0]  cnt;
  logic             cy, zt;
  logic             accept, is_alu, is_logic, is_sub, last, cin;
  logic [LW-1:0]    a_s, k_s, b_s, r_s;
  logic [LW:0]      sum;
  logic             c_msb;
  int               base;

  assign rx_ready       = (state_q == S_IDLE);
  assign tx_busy        = (state_q == S_EXEC);
  assign tx_accumulator = acc;
  assign accept         = rx_valid & rx_ready;
  assign is_alu         = (rx_opcode >= OP_ADC) && (rx_opcode <= OP_XOR);
  assign is_logic       = (op_q >= OP_AND);
  assign is_sub         = (op_q == OP_SBC) || (op_q == OP_SUB);

`ifdef ACCUMULATOR_SERIAL_PARALLEL_EN
  assign base = 0;
  assign last = 1'b1;
`else
  assign base = 4 * int'(cnt);
  assign last = (cnt == SELW'(NYB - 1));
`endif

  // Carry-in chosen at acceptance: subtraction is add-of-complement with carry 1.
  always_comb begin
    cin = 1'b0;
    case (rx_opcode)
      OP_ADC, OP_SBC: cin = rx_carry;
      OP_SUB:         cin = 1'b1;
      default:        cin = 1'b0;
    endcase
  end

  always_comb begin
    a_s   = acc[base +: LW];
    k_s   = konst[base +: LW];
    b_s   = is_sub ? ~k_s : k_s;
    sum   = {1'b0, a_s} + {1'b0, b_s} + {{LW{1'b0}}, cy};
    c_msb = a_s[LW-1] ^ b_s[LW-1] ^ sum[LW-1];
    case (op_q)
      OP_AND:  r_s = a_s & k_s;
      OP_OR:   r_s = a_s | k_s;
      OP_XOR:  r_s = a_s ^ k_s;
      default: r_s = sum[LW-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_alu) state_d = S_EXEC;
      S_EXEC:  if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      acc         <= '0;
      konst       <= '0;
      op_q        <= '0;
      cnt         <= '0;
      cy          <= 1'b0;
      zt          <= 1'b0;
      tx_zero     <= 1'b0;
      tx_sign     <= 1'b0;
      tx_carry    <= 1'b0;
      tx_overflow <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state_q == S_EXEC) begin
        acc[base +: LW] <= r_s;
        cy  <= sum[LW];
        zt  <= zt & ~|r_s;
        cnt <= cnt + 1'b1;
        if (last) begin
          tx_zero     <= zt & ~|r_s;
          tx_sign     <= r_s[LW-1];
          tx_carry    <= is_logic ? 1'b0 : sum[LW];
          tx_overflow <= is_logic ? 1'b0 : (c_msb ^ sum[LW]);
          tx_done     <= 1'b1;
        end
      end else if (accept) begin
        case (rx_opcode)
          OP_LDA:  if (int'(rx_sel) < NYB) acc[4*int'(rx_sel) +: 4] <= rx_operand;
          OP_LDK:  if (int'(rx_sel) < NYB) konst[4*int'(rx_sel) +: 4] <= rx_operand;
          OP_CLR:  acc <= '0;
          OP_XCHG: begin
            acc   <= konst;
            konst <= acc;
          end
          default: ;
        endcase
        if (is_alu) begin
          op_q <= rx_opcode;
          cnt  <= '0;
          cy   <= cin;
          zt   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_accumulator_serial.sv
// Directed bench for accumulator_serial (WIDTH=16) with immediate-assertion checks.
module tb_accumulator_serial;
  localparam int WIDTH = 16;
`ifdef ACCUMULATOR_SERIAL_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif
  localparam logic [4:0] NOP = 5'd0, LDA = 5'd1, LDK = 5'd2, CLR = 5'd3, ADC = 5'd4,
                         ADD = 5'd5, SBC = 5'd6, SUB = 5'd7, AND_ = 5'd8, XOR_ = 5'd10,
                         XCHG = 5'd11, OP20 = 5'd20;

  logic             aclk = 1'b0, areset = 1'b0;
  logic             rx_valid = 1'b0, rx_ready, rx_carry = 1'b0;
  logic [4:0]       rx_opcode = '0;
  logic [1:0]       rx_sel = '0;
  logic [3:0]       rx_operand = '0;
  logic [WIDTH-1:0] tx_accumulator;
  logic             tx_zero, tx_sign, tx_carry, tx_overflow, tx_busy, tx_done;
  int               n_chk = 0, n_fail = 0;
  int               lowc, donec;

  accumulator_serial #(.WIDTH(WIDTH)) dut (
    .aclk(aclk), .areset(areset), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_opcode(rx_opcode), .rx_sel(rx_sel), .rx_operand(rx_operand), .rx_carry(rx_carry),
    .tx_accumulator(tx_accumulator), .tx_zero(tx_zero), .tx_sign(tx_sign),
    .tx_carry(tx_carry), .tx_overflow(tx_overflow), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flags(input string tag, input logic z, input logic s, input logic c, input logic v);
    chk({tag, "_flags"}, {28'd0, tx_zero, tx_sign, tx_carry, tx_overflow}, {28'd0, z, s, c, v});
  endtask

  task automatic cmd(input logic [4:0] op, input logic [1:0] sel, input logic [3:0] nyb,
                     input logic cin);
    @(negedge aclk);
    rx_opcode = op; rx_sel = sel; rx_operand = nyb; rx_carry = cin; rx_valid = 1'b1;
    @(posedge aclk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic load(input logic [4:0] op, input logic [15:0] v);
    for (int i = 0; i < 4; i++) cmd(op, 2'(i), v[4*i +: 4], 1'b0);
  endtask

  // Issues an ALU op, then samples ready/done for a bounded window of cycles.
  task automatic alu(input logic [4:0] op, input logic cin);
    cmd(op, 2'd0, 4'd0, cin);
    lowc = 0; donec = 0;
    for (int i = 0; i < 10; i++) begin
      if (!rx_ready) lowc++;
      if (tx_done) donec++;
      @(posedge aclk); #1;
    end
  endtask

  initial begin
    // 1: reset
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    chk("rst_acc", 32'(tx_accumulator), 32'h0);
    flags("rst", 0, 0, 0, 0);
    chk("rst_ctl", {29'd0, rx_ready, tx_busy, tx_done}, {29'd0, 3'b100});

    // 2: loads and ADD
    load(LDA, 16'h12F4);
    chk("lda", 32'(tx_accumulator), 32'h12F4);
    load(LDK, 16'h0E0C);
    alu(ADD, 1'b0);
    chk("add_acc", 32'(tx_accumulator), 32'h2100);
    flags("add", 0, 0, 0, 0);
    chk("add_ready_low", lowc, LAT);
    chk("add_done_pulses", donec, 1);

    // 3: ADC with carry-in wrapping to zero
    load(LDA, 16'hFFFF);
    load(LDK, 16'h0000);
    alu(ADC, 1'b1);
    chk("adc_acc", 32'(tx_accumulator), 32'h0);
    flags("adc", 1, 0, 1, 0);

    // 4: SUB with signed overflow, then XOR
    load(LDA, 16'h8000);
    load(LDK, 16'h0001);
    alu(SUB, 1'b0);
    chk("sub_acc", 32'(tx_accumulator), 32'h7FFF);
    flags("sub", 0, 0, 1, 1);
    load(LDA, 16'hA5A5);
    load(LDK, 16'hFFFF);
    alu(XOR_, 1'b0);
    chk("xor_acc", 32'(tx_accumulator), 32'h5A5A);
    flags("xor", 0, 0, 0, 0);

    // 5: XCHG held valid during ADD; 5A5A+FFFF = 5A59 carry out
    @(negedge aclk);
    rx_opcode = ADD; rx_carry = 1'b0; rx_valid = 1'b1;
    @(posedge aclk); #1;
    rx_opcode = XCHG;
    for (int i = 0; i < LAT; i++) begin
      chk("hold_busy", {31'd0, rx_ready}, 32'd0);
      @(posedge aclk); #1;
    end
    chk("hold_done_ready", {30'd0, tx_done, rx_ready}, 32'd3);
    chk("hold_add_acc", 32'(tx_accumulator), 32'h5A59);
    @(posedge aclk); #1;
    rx_valid = 1'b0;
    chk("xchg_acc", 32'(tx_accumulator), 32'hFFFF);
    chk("xchg_no_done", {31'd0, tx_done}, 32'd0);
    flags("xchg", 0, 0, 1, 0);
    cmd(XCHG, 2'd0, 4'd0, 1'b0);
    chk("xchg_back", 32'(tx_accumulator), 32'h5A59);
    cmd(OP20, 2'd3, 4'h7, 1'b1);
    cmd(NOP, 2'd1, 4'h3, 1'b0);
    chk("nop_acc", 32'(tx_accumulator), 32'h5A59);
    flags("nop", 0, 0, 1, 0);

    // 6: reset mid-op
    cmd(ADD, 2'd0, 4'd0, 1'b0);
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    chk("mid_rst_acc", 32'(tx_accumulator), 32'h0);
    flags("mid_rst", 0, 0, 0, 0);
    chk("mid_rst_ctl", {29'd0, rx_ready, tx_busy, tx_done}, {29'd0, 3'b100});
    donec = 0;
    for (int i = 0; i < 8; i++) begin
      if (tx_done) donec++;
      @(posedge aclk); #1;
    end
    chk("mid_rst_no_done", donec, 0);
    cmd(LDA, 2'd0, 4'h3, 1'b0);
    cmd(XCHG, 2'd0, 4'd0, 1'b0);
    chk("mid_rst_const", 32'(tx_accumulator), 32'h0);

    // SBC with borrow, then AND, then CLR
    load(LDA, 16'h0005);
    load(LDK, 16'h0007);
    alu(SBC, 1'b0);
    chk("sbc_acc", 32'(tx_accumulator), 32'hFFFD);
    flags("sbc", 0, 1, 0, 0);
    alu(AND_, 1'b0);
    chk("and_acc", 32'(tx_accumulator), 32'h0005);
    flags("and", 0, 0, 0, 0);
    cmd(CLR, 2'd0, 4'd0, 1'b0);
    chk("clr_acc", 32'(tx_accumulator), 32'h0);
    flags("clr", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/accumulator_serial.md
Name: accumulator_serial

Overview:
Parametrised WIDTH-bit accumulator with an operand (constant) register, both loaded one nybble at a time from a 4-bit operand bus.
- Arithmetic and logic ops run bit-serially, one nybble per cycle, over WIDTH/4 cycles.
- A valid/ready handshake fronts the block; ZERO/SIGN/CARRY/OVERFLOW flags are produced at completion.
- It is the wide, multi-cycle generation of the 8-bit nybble accumulator in the datapath core.

Parameters:
WIDTH, 16, accumulator/constant width in bits; multiple of 4, >= 8
NYB, WIDTH/4, derived; number of nybbles, not user-overridable
SELW, max(1,$clog2(NYB)), derived; nybble-select width

Ports:
aclk  in  1  clock; all state on rising edge
areset  in  1  synchronous reset, active-high
rx_valid  in  1  command valid
rx_ready  out  1  block can accept a command (high only in IDLE)
rx_opcode  in  5  command opcode
rx_sel  in  SELW  nybble index for load ops
rx_operand  in  4  nybble data for load ops
rx_carry  in  1  carry-in for ADC/SBC, sampled at acceptance
tx_accumulator  out  WIDTH  accumulator register
tx_zero  out  1  last ALU result == 0
tx_sign  out  1  last ALU result MSB
tx_carry  out  1  last ALU carry-out (SUB/SBC: 1 = no borrow)
tx_overflow  out  1  last ALU signed overflow
tx_busy  out  1  serial op in progress
tx_done  out  1  one-cycle pulse on ALU op completion

Behaviour:
- Reset (areset high at edge, priority over everything, including mid-op):
  - accumulator=0, constant=0, all flags 0, tx_done=0, state=IDLE, nybble counter=0.
- Acceptance: rx_valid & rx_ready at a rising edge. Not accepted -> no state change.
- Opcodes:
  - 0 NOP.
  - 1 LDA: acc[4*sel+:4] <= operand.
  - 2 LDK: const[4*sel+:4] <= operand.
  - 3 CLR: acc <= 0.
  - 4 ADC: acc+const+rx_carry.
  - 5 ADD: acc+const.
  - 6 SBC: acc+~const+rx_carry.
  - 7 SUB: acc+~const+1.
  - 8 AND, 9 OR, 10 XOR.
  - 11 XCHG: swap acc and const.
  - 12-31: treated as NOP.
- Single-cycle ops (0-3, 11, 12-31):
  - Take effect at the acceptance edge; state stays IDLE; flags unchanged; no tx_done.
- Load with rx_sel >= NYB: accepted, no register write.
- ALU ops (4-10), FSM IDLE -> EXEC -> IDLE:
  - Acceptance edge E0: state=EXEC, counter=0, internal carry = carry-in (ADC/SBC: rx_carry; ADD: 0; SUB: 1; logic: 0), zero-tracker=1.
  - Edge Ek (k=1..NYB): writes result nybble k-1 into acc, updates internal carry and zero-tracker (AND of nybble==0), increments counter.
  - Edge E_NYB also: state=IDLE; flags latched:
    - zero = tracker & (last nybble==0)
    - sign = result MSB
    - carry = final carry-out; 0 for logic ops
    - overflow = carry into bit WIDTH-1 XOR carry-out; 0 for logic ops
  - tx_done=1 for exactly the cycle after E_NYB; rx_ready is 1 in that same cycle (back-to-back accept allowed).
- rx_ready = (state==IDLE); tx_busy = (state==EXEC). rx_ready is low for exactly NYB cycles per ALU op.
- Constant register is stable during EXEC, since no loads are accepted while busy.
- Accumulator bits not yet processed retain old values mid-op. Intermediate tx_accumulator values during EXEC are architecturally visible but defined only as above.
- Arithmetic wraps modulo 2^WIDTH.

Optional Feature:
Macro ACCUMULATOR_SERIAL_PARALLEL_EN.
- Defined:
  - ALU ops compute full-width in one EXEC cycle: acceptance edge E0 -> result, flags and state=IDLE at E1.
  - tx_done is high in the cycle after E1; rx_ready is low for 1 cycle.
  - Results and flags are bit-identical to serial mode.
- Undefined: serial NYB-cycle behaviour above.

Test Plan:
(all scenarios WIDTH=16, NYB=4)
1. areset high 2 cycles, then low -> tx_accumulator=0x0000, all flags 0, rx_ready=1, tx_busy=0, tx_done=0.
2. LDA sel0..3 = 4,F,2,1 (acc=0x12F4); LDK sel0..3 = C,0,E,0 (const=0x0E0C); ADD -> rx_ready low 4 cycles, then acc=0x2100, carry=0, zero=0, sign=0, overflow=0; tx_done exactly one pulse.
3. acc=0xFFFF, const=0x0000, ADC with rx_carry=1 -> acc=0x0000, carry=1, zero=1, sign=0, overflow=0.
4. acc=0x8000, const=0x0001, SUB -> acc=0x7FFF, carry=1, overflow=1, sign=0, zero=0; then XOR with const=0xFFFF on acc=0xA5A5 -> 0x5A5A, carry=0, overflow=0.
5. Hold rx_valid with XCHG during an ADD's EXEC -> XCHG accepted only in the tx_done cycle; afterwards acc/const swapped and flags unchanged; load with rx_sel=5 (SELW=2 wraps) ignored is N/A, so use NOP/opcode 20 -> no change.
6. Start ADD, assert areset at E2 -> next cycle acc=0, const=0, flags 0, rx_ready=1, no tx_done pulse ever issued for that op.
